// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents {pc, instruction, pc+4} to decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_8000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_npc_default,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_IDLE} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        drop_q, drop_d;
  logic        misalign_q, misalign_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    drop_d     = drop_q;
    misalign_d = 1'b0;

    unique case (state_q)
      S_REQ:   if (imem_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rdata;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (id_ready) begin
          inst_d  = NOP_INST;
          state_d = S_IDLE;
        end
      end
      default: state_d = state_q;
    endcase

    // A redirect overrides whatever the state machine decided above.
    if (npc_valid) begin
      pc_d       = {npc[31:2], 2'b00};
      misalign_d = |npc[1:0];
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_VALID: begin
          inst_d  = NOP_INST;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (imem_gnt) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        default: begin
          if (imem_rvalid) begin
            inst_d  = NOP_INST;
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  // The reset state is REQ, so the request must be gated while reset is held.
  assign imem_req       = rst_n & (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign if_valid       = (state_q == S_VALID);
  assign if_pc          = pc_q;
  assign if_inst        = inst_q;
  assign if_npc_default = pc_q + 32'd4;
  assign misalign_err   = misalign_q;

endmodule
